imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch addresses the program counter issues; the other end of the PC→IMEM fetch interface.
- Accepts word-aligned fetch requests via valid/ready and returns the 32-bit instruction after a fixed LATENCY. Applies backpressure on the response side.
- On reset, a clear sequence fills memory with NOP. A load port then writes the program image before and between fetches.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of 2, 16..4096.
- LATENCY, 1, request-accept to rsp_valid in cycles; legal 1..4.
- NOP_WORD, 32'h00000013, word used for clear fill and fault responses (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  request accepted this cycle when req_valid && req_ready.
- req_addr  input  32  byte address from PC.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
- rsp_instr  output  32  instruction word.
- rsp_fault  output  1  request was misaligned or out of range.
- ld_en  input  1  load-port write strobe.
- ld_ready  output  1  load write accepted when ld_en && ld_ready.
- ld_addr  input  32  load byte address; bits [1:0] ignored.
- ld_data  input  32  word to write.
- busy  output  1  high while in CLEAR.

Behaviour:
- Reset (rst=0, async): state=CLEAR, clear counter=0, all pipeline valid bits=0.
  - Outputs during and after reset: rsp_valid=0, rsp_instr=0, rsp_fault=0, req_ready=0, ld_ready=0, busy=1.
  - Memory array is not reset.
- FSM has two states, CLEAR and RUN.
  - CLEAR: writes NOP_WORD to word[cnt] each cycle, cnt increments. After cnt==DEPTH_WORDS-1 is written, moves to RUN (DEPTH_WORDS cycles total). busy=1; req_ready=0; ld_ready=0.
  - RUN: busy=0; never returns to CLEAR except via reset.
- Load port (RUN only):
  - ld_ready=1 in RUN.
  - Write index = ld_addr[log2(DEPTH)+1:2]. Writes to index >= DEPTH_WORDS (any upper bit set) are dropped silently.
  - Load has priority over fetch: req_ready=0 in any cycle with ld_en=1.
  - A fetch accepted in a later cycle to the same word returns the new data; no write-to-read bypass in the same cycle.
- Request accept: req_ready = RUN && !ld_en && !stall, where stall = rsp_valid && !rsp_ready.
- Fault classification at accept:
  - fault if req_addr[1:0]!=0 OR req_addr[31:2] >= DEPTH_WORDS.
  - On fault: rsp_instr=NOP_WORD, rsp_fault=1.
  - Otherwise: rsp_instr=mem[req_addr>>2], rsp_fault=0.
- Pipeline:
  - LATENCY stages of {valid, instr, fault}. Array read at accept; result enters stage 1.
  - With no stall, rsp_valid rises exactly LATENCY cycles after the accepting edge.
  - Back-to-back accepts give one response per cycle, in order.
- Stall: while stall=1, every stage holds. rsp_instr and rsp_fault stay stable while rsp_valid=1 && rsp_ready=0. No request is accepted, none is dropped, none is duplicated.
- Idle output: rsp_instr/rsp_fault hold their last values when rsp_valid=0.
- Reset mid-operation: all in-flight responses are discarded. CLEAR restarts from cnt=0 even if the previous CLEAR was incomplete.

Optional Feature:
- Macro IMEM_FAULT_CNT_EN.
- Defined: adds output fault_cnt [15:0], reset to 0. Increments by 1 on each rsp_valid && rsp_ready && rsp_fault handshake and saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then hold req_valid=1 → busy=1 and req_ready=0 for 256 cycles (DEPTH_WORDS=256); then busy=0, req_ready=1. Fetch 0x00000040 → rsp_instr=32'h00000013, rsp_fault=0.
- Load 0x00000000←32'h00500093 and 0x00000004←32'h00A00113, then fetch 0x0, 0x4 back-to-back with LATENCY=1 → responses on consecutive cycles, in order: 32'h00500093 then 32'h00A00113.
- Fetch 0x00000002 and 0x00000400 (DEPTH 256) → both rsp_fault=1, rsp_instr=32'h00000013. With IMEM_FAULT_CNT_EN: fault_cnt=2.
- LATENCY=3, issue 4 fetches, then hold rsp_ready=0 for 5 cycles → req_ready=0 while stalled, rsp_instr stable. Releasing rsp_ready yields exactly 4 responses in order.
- ld_en=1 and req_valid=1 in the same cycle → req_ready=0, load written. Fetch of that address next cycle → returns the new word.
- Assert rst=0 mid-stream with 2 responses in flight → rsp_valid=0 immediately. After release: busy=1 for 256 cycles; previously loaded words read back as 32'h00000013.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the PC fetch interface.
// On reset it fills the array with NOP_WORD (CLEAR), then serves word-aligned
// fetches with a fixed LATENCY and accepts program-image writes on the load port.
// Optional: define IMEM_FAULT_CNT_EN to add a saturating fault_cnt output.
module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        ld_en,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
`ifdef IMEM_FAULT_CNT_EN
  ,
  output logic [15:0] fault_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [31:0]               mem [DEPTH_WORDS];

  logic                      wr_en;
  logic [AW-1:0]             wr_idx;
  logic [31:0]               wr_data;

  logic [LATENCY:1]          vld_pipe_q;
  logic [LATENCY:1][31:0]    instr_pipe_q;
  logic [LATENCY:1]          fault_pipe_q;

  logic                      stall;
  logic                      accept;
  logic                      req_fault;
  logic                      ld_oob;
  logic [31:0]               rd_data;
  logic                      unused_ld_lsb;

  // Load byte-lane bits carry no meaning for word writes.
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign rsp_valid = vld_pipe_q[LATENCY];
  assign rsp_instr = instr_pipe_q[LATENCY];
  assign rsp_fault = fault_pipe_q[LATENCY];

  // Whole pipeline freezes while the consumer refuses a presented response.
  assign stall     = rsp_valid & ~rsp_ready;
  assign accept    = req_valid & req_ready;
  assign req_fault = (req_addr[1:0] != 2'b00) | (req_addr[31:AW+2] != '0);
  assign ld_oob    = (ld_addr[31:AW+2] != '0);
  assign rd_data   = req_fault ? NOP_WORD : mem[req_addr[AW+1:2]];

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, write-port steering and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_idx    = ld_addr[AW+1:2];
    wr_data   = ld_data;
    busy      = 1'b0;
    ld_ready  = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = NOP_WORD;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH_WORDS - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        ld_ready  = 1'b1;
        // Loads win the cycle; out-of-range loads are dropped silently.
        req_ready = ~ld_en & ~stall;
        wr_en     = ld_en & ~ld_oob;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and the load port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Response pipeline; payload only moves with a valid entry so the
  // output holds its last response while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q   <= '0;
      instr_pipe_q <= '0;
      fault_pipe_q <= '0;
    end else if (!stall) begin
      vld_pipe_q[1] <= accept;
      if (accept) begin
        instr_pipe_q[1] <= rd_data;
        fault_pipe_q[1] <= req_fault;
      end
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) begin
          instr_pipe_q[i] <= instr_pipe_q[i-1];
          fault_pipe_q[i] <= fault_pipe_q[i-1];
        end
      end
    end
  end

`ifdef IMEM_FAULT_CNT_EN
  logic [15:0] fault_cnt_q;

  // Count faulted responses actually taken by the consumer, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready && rsp_fault && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY 1 and 3) share stimulus and
// are checked every cycle against a queue-based reference model.
module tb_imem_responder;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, rsp_ready, ld_en;
  logic [31:0] req_addr, ld_addr, ld_data;
  logic [1:0]  o_req_ready, o_rsp_valid, o_rsp_fault, o_ld_ready, o_busy;
  logic [1:0][31:0] o_rsp_instr;
`ifdef IMEM_FAULT_CNT_EN
  logic [1:0][15:0] o_fcnt;
`endif

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(o_req_ready[0]), .req_addr(req_addr),
    .rsp_valid(o_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_instr(o_rsp_instr[0]),
    .rsp_fault(o_rsp_fault[0]),
    .ld_en(ld_en), .ld_ready(o_ld_ready[0]), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(o_busy[0])
`ifdef IMEM_FAULT_CNT_EN
    , .fault_cnt(o_fcnt[0])
`endif
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .NOP_WORD(NOP)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(o_req_ready[1]), .req_addr(req_addr),
    .rsp_valid(o_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_instr(o_rsp_instr[1]),
    .rsp_fault(o_rsp_fault[1]),
    .ld_en(ld_en), .ld_ready(o_ld_ready[1]), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(o_busy[1])
`ifdef IMEM_FAULT_CNT_EN
    , .fault_cnt(o_fcnt[1])
`endif
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: memory image, per-instance in-flight queue with ages.
  int          lat [2] = '{1, 3};
  logic [31:0] mem_m [DEPTH];
  logic [31:0] q_instr [2][64];
  logic        q_fault [2][64];
  int          q_age   [2][64];
  int          hd [2], tl [2];
  logic [31:0] last_instr [2];
  logic        last_fault [2];
  int          fcnt [2];
  int          clr;
  bit          run_m;

  // Responses observed leaving each DUT, for directed checks.
  logic [31:0] pop_instr [2][64];
  logic        pop_fault [2][64];
  int          pop_cyc   [2][64];
  int          npop [2];
  int          cyc = 0;

  function automatic bit exp_valid(input int k);
    return (tl[k] != hd[k]) && (q_age[k][hd[k] % 64] == lat[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; last_instr[k] = '0; last_fault[k] = 1'b0; fcnt[k] = 0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    clr = 0;
    run_m = 1'b0;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      bit ev, err;
      logic [31:0] ei;
      logic ef;
      ev  = exp_valid(k);
      ei  = ev ? q_instr[k][hd[k] % 64] : last_instr[k];
      ef  = ev ? q_fault[k][hd[k] % 64] : last_fault[k];
      err = run_m && !ld_en && !(ev && !rsp_ready);
      chk($sformatf("L%0d busy", lat[k]),      32'(o_busy[k]),      32'(!run_m));
      chk($sformatf("L%0d ld_ready", lat[k]),  32'(o_ld_ready[k]),  32'(run_m));
      chk($sformatf("L%0d req_ready", lat[k]), 32'(o_req_ready[k]), 32'(err));
      chk($sformatf("L%0d rsp_valid", lat[k]), 32'(o_rsp_valid[k]), 32'(ev));
      chk($sformatf("L%0d rsp_instr", lat[k]), o_rsp_instr[k],      ei);
      chk($sformatf("L%0d rsp_fault", lat[k]), 32'(o_rsp_fault[k]), 32'(ef));
`ifdef IMEM_FAULT_CNT_EN
      chk($sformatf("L%0d fault_cnt", lat[k]), 32'(o_fcnt[k]),      32'(fcnt[k]));
`endif
      if (o_rsp_valid[k] === 1'b1 && rsp_ready && npop[k] < 64) begin
        pop_instr[k][npop[k]] = o_rsp_instr[k];
        pop_fault[k][npop[k]] = o_rsp_fault[k];
        pop_cyc[k][npop[k]]   = cyc;
        npop[k]++;
      end
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit ev, stall, acc, flt;
        ev    = exp_valid(k);
        stall = ev && !rsp_ready;
        acc   = req_valid && run_m && !ld_en && !stall;
        if (ev && rsp_ready) begin
          last_instr[k] = q_instr[k][hd[k] % 64];
          last_fault[k] = q_fault[k][hd[k] % 64];
          if (last_fault[k] && fcnt[k] < 65535) fcnt[k]++;
          hd[k]++;
        end
        if (!stall) for (int i = hd[k]; i < tl[k]; i++) q_age[k][i % 64]++;
        if (acc) begin
          flt = (req_addr % 4 != 0) || ((req_addr >> 2) >= DEPTH);
          q_instr[k][tl[k] % 64] = flt ? NOP : mem_m[req_addr[9:2]];
          q_fault[k][tl[k] % 64] = flt;
          q_age[k][tl[k] % 64]   = 1;
          tl[k]++;
        end
      end
      if (run_m && ld_en && ((ld_addr >> 2) < DEPTH)) mem_m[ld_addr[9:2]] = ld_data;
      if (!run_m) begin
        clr++;
        if (clr == DEPTH) run_m = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    ld_en     = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clear_log();
    npop[0] = 0;
    npop[1] = 0;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (o_busy[0] === 1'b1 && n < 400) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    clear_log();
    model_reset();
    #2 rst = 1'b0;
    cycle();
    cycle();

    // Clear sweep with a fetch already waiting, then that fetch completes.
    req_valid = 1'b1; req_addr = 32'h40;
    rst = 1'b1;
    wait_clear("clear_cycles");
    cycle();
    idle(4);
    chk("fetch40 count", 32'(npop[0]), 32'd1);
    chk("fetch40 instr", pop_instr[0][0], NOP);
    chk("fetch40 fault", 32'(pop_fault[0][0]), 32'd0);

    // Load two words then read them back-to-back.
    ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h00500093; cycle();
    ld_addr = 32'h4; ld_data = 32'h00A00113; cycle();
    ld_en = 1'b0;
    clear_log();
    req_valid = 1'b1; req_addr = 32'h0; cycle();
    req_addr = 32'h4; cycle();
    idle(6);
    chk("b2b first",  pop_instr[0][0], 32'h00500093);
    chk("b2b second", pop_instr[0][1], 32'h00A00113);
    chk("b2b spacing", 32'(pop_cyc[0][1] - pop_cyc[0][0]), 32'd1);
    chk("b2b L3 second", pop_instr[1][1], 32'h00A00113);

    // Misaligned and out-of-range fetches.
    clear_log();
    req_valid = 1'b1; req_addr = 32'h2; cycle();
    req_addr = 32'h400; cycle();
    idle(6);
    chk("misalign fault", 32'(pop_fault[0][0]), 32'd1);
    chk("misalign instr", pop_instr[0][0], NOP);
    chk("oob fault", 32'(pop_fault[1][1]), 32'd1);
    chk("oob instr", pop_instr[1][1], NOP);
`ifdef IMEM_FAULT_CNT_EN
    chk("fault_cnt two", 32'(o_fcnt[0]), 32'd2);
`endif

    // Four fetches then a 5-cycle consumer stall.
    clear_log();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      cycle();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    cycle();
    begin
      logic [31:0] held;
      held = o_rsp_instr[1];
      chk("stall valid", 32'(o_rsp_valid[1]), 32'd1);
      repeat (4) begin
        cycle();
        chk("stall instr stable", o_rsp_instr[1], held);
        chk("stall req_ready", 32'(o_req_ready[1]), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    idle(6);
    chk("stall count", 32'(npop[1]), 32'd4);
    chk("stall order0", pop_instr[1][0], 32'h00500093);
    chk("stall order1", pop_instr[1][1], 32'h00A00113);
    chk("stall order2", pop_instr[1][2], NOP);
    chk("stall order3", pop_instr[1][3], NOP);

    // Load and fetch collide; load wins, fetch then sees the new word.
    clear_log();
    ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h20;
    #1;
    chk("collide req_ready", 32'(o_req_ready[0]), 32'd0);
    cycle();
    ld_en = 1'b0;
    cycle();
    idle(6);
    chk("collide count", 32'(npop[0]), 32'd1);
    chk("collide data", pop_instr[0][0], 32'hDEADBEEF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r, w;
      ld_en   = ($urandom_range(0, 4) == 0);
      ld_addr = 32'($urandom_range(0, 299)) << 2;
      ld_data = $urandom;
      req_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 279);
      if (r == 0)      req_addr = $urandom;
      else if (r == 1) req_addr = (32'(w) << 2) | 32'($urandom_range(1, 3));
      else             req_addr = 32'(w) << 2;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rsp_ready = 1'b1;
    idle(8);

    // Reset with responses in flight.
    ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h12345678; cycle();
    ld_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; cycle();
    req_addr = 32'h4; cycle();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst L1 valid", 32'(o_rsp_valid[0]), 32'd0);
    chk("midrst L3 valid", 32'(o_rsp_valid[1]), 32'd0);
    model_reset();
    cycle();
    cycle();
    clear_log();
    rst = 1'b1;
    wait_clear("reclear_cycles");
    req_valid = 1'b1; req_addr = 32'h0; cycle();
    req_addr = 32'h4; cycle();
    idle(6);
    chk("reclear count", 32'(npop[1]), 32'd2);
    chk("reclear word0", pop_instr[1][0], NOP);
    chk("reclear word1", pop_instr[1][1], NOP);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
